// File: rtl/filter_frame_ctrl.sv
// rtl/filter_frame_ctrl.sv - frame sequencer between raster source and 3x3 filter datapath
// Admits one frame of input beats, counts and tags filter outputs, reports done/errors.
module filter_frame_ctrl #(
  parameter  int DWIDTH  = 10,
  parameter  int PIXCNT  = 8,
  parameter  int ROWS    = 2049,
  parameter  int COLS    = 2448,
  parameter  int TIMEOUT = 4096,
  localparam int RW      = $clog2(ROWS),
  localparam int CW      = $clog2(COLS),
  localparam int BW      = $clog2(ROWS * (COLS / PIXCNT) + 1),
  localparam int DW      = DWIDTH * PIXCNT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [RW-1:0] cfg_rows,
  input  logic [CW-1:0] cfg_cols,
  input  logic          cfg_bypass,
  output logic          busy,
  output logic          done,
  output logic          err_cfg,
  output logic          err_timeout,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          f_new_frame,
  output logic [RW-1:0] f_rows,
  output logic [CW-1:0] f_cols,
  output logic          f_bypass,
  output logic [DW-1:0] f_data,
  output logic          f_vld,
  input  logic [DW-1:0] f_out_data,
  input  logic          f_out_vld,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  output logic          m_sof,
  output logic          m_eol,
  output logic          m_eof
);

  localparam int PW = $clog2(PIXCNT);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, CLEAR, RUN, DRAIN, DONE} state_t;

  state_t        state, state_nxt;
  logic [BW-1:0] total, in_cnt, out_cnt;
  logic [CW-1:0] col_cnt, bpr;
  logic [TW-1:0] idle_cnt;
  logic          clr_cnt;
  logic          cfg_ok, accept, fwd, timeout_hit, start_ok;

  assign bpr      = f_cols >> PW;
  assign cfg_ok   = ((cfg_cols % CW'(PIXCNT)) == '0) && (cfg_cols >= CW'(2 * PIXCNT))
                    && (cfg_rows >= RW'(3));
  assign start_ok = (state == IDLE) && start && cfg_ok;
  assign accept   = s_valid && s_ready;
  assign fwd      = f_out_vld && ((state == RUN) || (state == DRAIN)) && (out_cnt != total);
  // A beat arriving in the same cycle rescues the frame from timing out.
  assign timeout_hit = (state == DRAIN) && (out_cnt != total) && !fwd
                       && (idle_cnt == TW'(TIMEOUT - 1));

  assign busy   = (state != IDLE);
  assign f_vld  = accept;
  assign f_data = s_ready ? s_data : '0;

  always_comb begin
    state_nxt   = state;
    s_ready     = 1'b0;
    f_new_frame = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE:  if (start_ok) state_nxt = CLEAR;
      CLEAR: begin
        f_new_frame = 1'b1;
        if (clr_cnt) state_nxt = RUN;
      end
      RUN: begin
        s_ready = 1'b1;
        if (accept && (in_cnt == total - BW'(1))) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (out_cnt == total) begin
          state_nxt = DONE;
        end else if (timeout_hit) begin
          f_new_frame = 1'b1;
          state_nxt   = IDLE;
        end
      end
      DONE: begin
        f_new_frame = 1'b1;
        done        = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      clr_cnt     <= 1'b0;
      err_cfg     <= 1'b0;
      err_timeout <= 1'b0;
      f_rows      <= '0;
      f_cols      <= '0;
      f_bypass    <= 1'b0;
      total       <= '0;
      in_cnt      <= '0;
      out_cnt     <= '0;
      col_cnt     <= '0;
      idle_cnt    <= '0;
      m_data      <= '0;
      m_valid     <= 1'b0;
      m_sof       <= 1'b0;
      m_eol       <= 1'b0;
      m_eof       <= 1'b0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= (state == CLEAR) ? ~clr_cnt : 1'b0;
      err_cfg <= (state == IDLE) && start && !cfg_ok;
      if (start_ok) begin
        f_rows      <= cfg_rows;
        f_cols      <= cfg_cols;
        f_bypass    <= cfg_bypass;
        err_timeout <= 1'b0;
      end else if (timeout_hit) begin
        err_timeout <= 1'b1;
      end
      if (state == CLEAR) begin
        total   <= BW'(f_rows) * BW'(bpr);
        in_cnt  <= '0;
        out_cnt <= '0;
        col_cnt <= '0;
      end
      if (accept) in_cnt <= in_cnt + BW'(1);
      if (fwd) begin
        out_cnt <= out_cnt + BW'(1);
        col_cnt <= (col_cnt == bpr - CW'(1)) ? '0 : col_cnt + CW'(1);
        m_data  <= f_out_data;
      end
      idle_cnt <= ((state == DRAIN) && !fwd) ? idle_cnt + TW'(1) : '0;
      m_valid  <= fwd;
      m_sof    <= fwd && (out_cnt == '0);
      m_eol    <= fwd && (col_cnt == bpr - CW'(1));
      m_eof    <= fwd && (out_cnt == total - BW'(1));
    end
  end

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// tb/tb_filter_frame_ctrl.sv - randomized self-checking bench for filter_frame_ctrl
// Frame-level reference model: beats in a queue, markers from beat index arithmetic.
module tb_filter_frame_ctrl;
  localparam int DWIDTH  = 10;
  localparam int PIXCNT  = 8;
  localparam int ROWS    = 2049;
  localparam int COLS    = 2448;
  localparam int TIMEOUT = 16;
  localparam int RW      = $clog2(ROWS);
  localparam int CW      = $clog2(COLS);
  localparam int DW      = DWIDTH * PIXCNT;

  logic          clk, reset, start, cfg_bypass;
  logic [RW-1:0] cfg_rows, f_rows;
  logic [CW-1:0] cfg_cols, f_cols;
  logic          busy, done, err_cfg, err_timeout;
  logic [DW-1:0] s_data, f_data, f_out_data, m_data;
  logic          s_valid, s_ready, f_new_frame, f_bypass, f_vld, f_out_vld;
  logic          m_valid, m_sof, m_eol, m_eof;

  int checks = 0;
  int errors = 0;

  filter_frame_ctrl #(
    .DWIDTH(DWIDTH), .PIXCNT(PIXCNT), .ROWS(ROWS), .COLS(COLS), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .cfg_bypass(cfg_bypass), .busy(busy), .done(done), .err_cfg(err_cfg),
    .err_timeout(err_timeout), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .f_new_frame(f_new_frame), .f_rows(f_rows), .f_cols(f_cols), .f_bypass(f_bypass),
    .f_data(f_data), .f_vld(f_vld), .f_out_data(f_out_data), .f_out_vld(f_out_vld),
    .m_data(m_data), .m_valid(m_valid), .m_sof(m_sof), .m_eol(m_eol), .m_eof(m_eof)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_beat();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[DW-1:0];
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_f_vld"}, f_vld, 0);
    check({tag, "_f_new_frame"}, f_new_frame, 0);
    check({tag, "_m_valid"}, {m_valid, m_sof, m_eol, m_eof}, 0);
    check({tag, "_f_cfg"}, {f_rows, f_cols, f_bypass}, 0);
    check({tag, "_err"}, {err_cfg, err_timeout}, 0);
  endtask

  task automatic cfg_err(input int rows, input int cols);
    int pulses = 0;
    bit busy_seen = 0, nf_seen = 0;
    @(negedge clk);
    cfg_rows = RW'(rows); cfg_cols = CW'(cols); start = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (err_cfg) pulses++;
      if (busy) busy_seen = 1;
      if (f_new_frame) nf_seen = 1;
    end
    check("err_cfg_pulses", pulses, 1);
    check("err_cfg_busy", busy_seen, 0);
    check("err_cfg_new_frame", nf_seen, 0);
  endtask

  // s_pct < 0 toggles s_valid 1-0-1-0; out_limit < total models a stalled filter.
  task automatic run_frame(input int rows, input int cols, input bit byp, input int s_pct,
                           input int out_limit, input int extra, input bit mid_start,
                           input int abort_acc);
    int total, bpr, acc, emitted, fwd_k, extra_sent, done_cnt, nf_cnt, rdy_cnt;
    int to_c, done_c, last_out_c, last_acc_c, last_eof_c, ref_c;
    bit expect_to, finished, ms_done, exp_v, exp_sof, exp_eol, exp_eof;
    logic [DW-1:0] exp_d, d;
    logic [DW-1:0] pend[$];
    total = rows * (cols / PIXCNT);
    bpr   = cols / PIXCNT;
    acc = 0; emitted = 0; fwd_k = 0; extra_sent = 0; done_cnt = 0; nf_cnt = 0; rdy_cnt = 0;
    to_c = -1; done_c = -1; last_out_c = 0; last_acc_c = 0; last_eof_c = -10;
    expect_to = (out_limit < total);
    finished = 0; ms_done = 0; exp_v = 0; exp_sof = 0; exp_eol = 0; exp_eof = 0; exp_d = '0;
    @(negedge clk);
    cfg_rows = RW'(rows); cfg_cols = CW'(cols); cfg_bypass = byp; start = 1'b1;
    s_valid = 1'b0; f_out_vld = 1'b0;
    for (int c = 1; c < 400; c++) begin
      @(negedge clk);
      if (c == 1) begin
        check("busy_rise", busy, 1);
        check("new_frame_c1", f_new_frame, 1);
        check("err_timeout_cleared", err_timeout, 0);
      end
      if (c == 2) begin
        check("new_frame_c2", f_new_frame, 1);
        check("s_ready_c2", s_ready, 0);
      end
      if (c == 3) begin
        check("s_ready_c3", s_ready, 1);
        check("new_frame_c3", f_new_frame, 0);
        check("f_cfg_latched", {f_rows, f_cols, f_bypass}, {RW'(rows), CW'(cols), byp});
      end
      check("m_valid", m_valid, exp_v);
      if (exp_v && m_valid) begin
        check("m_data", m_data, exp_d);
        check("m_markers", {m_sof, m_eol, m_eof}, {exp_sof, exp_eol, exp_eof});
        if (m_eof) last_eof_c = c;
      end
      if (f_new_frame) nf_cnt++;
      if (s_ready) rdy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_c < 0) begin
          done_c = c;
          check("done_after_eof", c, last_eof_c + 1);
          check("f_cfg_held", {f_rows, f_cols}, {RW'(rows), CW'(cols)});
        end
      end
      if (done_c >= 0 && c == done_c + 1) check("busy_fall", busy, 0);
      if (err_timeout && to_c < 0) begin
        to_c   = c;
        ref_c  = (last_out_c > last_acc_c) ? last_out_c : last_acc_c;
        check("timeout_delay", c - ref_c, TIMEOUT + 1);
        check("timeout_busy", busy, 0);
      end
      if (abort_acc > 0 && acc >= abort_acc) begin
        s_valid = 1'b0; f_out_vld = 1'b0; start = 1'b0;
        reset = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        @(negedge clk);
        reset = 1'b0;
        return;
      end
      if ((done_c >= 0 || to_c >= 0) && extra_sent == extra
          && c > ((done_c > to_c) ? done_c : to_c) + 3) begin
        finished = 1;
        break;
      end
      start = 1'b0;
      if (mid_start && acc == 2 && !ms_done) begin
        start = 1'b1; cfg_rows = RW'(rows + 1); cfg_cols = CW'(cols + 8); ms_done = 1;
      end
      s_valid = (s_pct < 0) ? (c % 2 == 1) : ($urandom_range(99) < s_pct);
      s_data  = rnd_beat();
      if (s_valid && s_ready) begin
        pend.push_back(s_data);
        acc++;
        last_acc_c = c;
      end
      exp_v = 0;
      f_out_vld = 1'b0;
      if (pend.size() > 0 && emitted < out_limit && $urandom_range(99) < 70) begin
        d = pend.pop_front();
        f_out_vld = 1'b1; f_out_data = ~d;
        emitted++; last_out_c = c;
        exp_v = 1; exp_d = ~d;
        exp_sof = (fwd_k == 0);
        exp_eol = ((fwd_k % bpr) == bpr - 1);
        exp_eof = (fwd_k == total - 1);
        fwd_k++;
      end else if (emitted == total && extra_sent < extra) begin
        f_out_vld = 1'b1; f_out_data = rnd_beat();
        extra_sent++;
      end
    end
    s_valid = 1'b0; f_out_vld = 1'b0; start = 1'b0;
    check("frame_completed", finished, 1);
    check("accepted_beats", acc, total);
    check("forwarded_beats", fwd_k, out_limit);
    check("done_count", done_cnt, expect_to ? 0 : 1);
    check("new_frame_count", nf_cnt, 3);
    check("err_timeout_end", err_timeout, expect_to);
    if (s_pct == 100) check("s_ready_cycles", rdy_cnt, total);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cfg_rows = '0; cfg_cols = '0; cfg_bypass = 1'b0;
    s_data = '0; s_valid = 1'b0; f_out_data = '0; f_out_vld = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    check_idle_outputs("post_reset");

    run_frame(4, 16, 1'b0, 100, 8, 0, 1'b0, 0);
    run_frame(4, 16, 1'b1, -1, 8, 0, 1'b0, 0);
    cfg_err(4, 20);
    cfg_err(2, 16);
    run_frame(4, 16, 1'b0, 100, 5, 0, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("err_timeout_sticky", err_timeout, 1);
    run_frame(4, 16, 1'b0, 100, 8, 3, 1'b1, 0);
    run_frame(4, 16, 1'b0, 100, 8, 0, 1'b0, 3);
    run_frame(4, 16, 1'b0, 100, 8, 0, 1'b0, 0);
    for (int i = 0; i < 6; i++) begin
      int r, cl, p;
      r  = $urandom_range(5, 3);
      cl = 8 * $urandom_range(5, 2);
      p  = $urandom_range(100, 30);
      run_frame(r, cl, 1'($urandom_range(1)), p, r * (cl / PIXCNT), 0, 1'b0, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
